r200_ifetch: RTL and testbench
==============================

Name: r200_ifetch

Overview:
- Instruction-fetch stage of the r200 RV32 pipeline, directly upstream of the decode stage.
- Owns the fetch PC and the single-outstanding-request handshake to instruction memory.
- Owns the IF/ID pipeline register, which supplies pc_addrout, pcp4 and instrn to decode.
- Consumes decode's pcsel/branchif/pc_brtarg and a jump target to redirect fetch, killing wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble placed in instrn when IF/ID holds no valid instruction (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; word aligned.
- imem_rvalid  in  1  read data valid; one pulse per accepted request.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- id_stall  in  1  decode cannot accept a new instruction this cycle.
- pcsel  in  2  from decoder: 00 sequential, 01 branch, 10 jump, 11 treated as sequential.
- branchif  in  1  branch condition resolved true.
- pc_brtarg  in  32  branch target.
- jmp_targ  in  32  jump target (jal/jalr).
- pc_addrout  out  32  PC of the instruction in IF/ID.
- pcp4  out  32  pc_addrout + 4.
- instrn  out  32  instruction in IF/ID; NOP_INSTR when instrn_valid=0.
- instrn_valid  out  1  IF/ID holds a live instruction.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - fetch_pc=RESET_PC; state=FETCH; imem_req=0.
  - instrn_valid=0; instrn=NOP_INSTR; pc_addrout=RESET_PC; pcp4=RESET_PC+4; skid buffer empty.
- Reset mid-request: an in-flight response arriving after reset is ignored (state FETCH with imem_req=0 sets no pending flag). Requests resume the cycle after rst falls.
- One outstanding request maximum. A pending flag sets when imem_req=1 and clears on imem_rvalid.
- imem_req=1 in FETCH and DISCARD whenever not pending, or pending with imem_rvalid this cycle (back-to-back allowed).
- imem_addr=fetch_pc, held stable while pending. Memory latency is at least 1 cycle and unbounded.
- redirect = instrn_valid & ((pcsel==01 & branchif) | pcsel==10).
  - target = pc_brtarg for a branch, jmp_targ for a jump; bits [1:0] forced to 0.
- State FETCH:
  - imem_rvalid & !redirect & !id_stall: load IF/ID (instrn=rdata, pc_addrout=fetch_pc, pcp4=fetch_pc+4, valid=1); fetch_pc+=4 (wraps mod 2^32).
  - imem_rvalid & !redirect & id_stall: capture rdata/fetch_pc in skid buffer, fetch_pc+=4, go HOLD. No new request while in HOLD.
  - !imem_rvalid & !id_stall & !redirect: IF/ID valid<=0, instrn<=NOP_INSTR.
  - id_stall & !redirect: IF/ID unchanged.
- State HOLD:
  - !id_stall & !redirect: move skid into IF/ID, go FETCH.
  - Otherwise hold; skid and IF/ID unchanged.
- redirect, from any state, has priority over id_stall:
  - IF/ID valid<=0, instrn<=NOP_INSTR; skid dropped; fetch_pc<=target.
  - Pending without rvalid this cycle: go DISCARD. Otherwise (including rvalid the same cycle, data dropped): go FETCH.
- State DISCARD: imem_req=0. The next imem_rvalid is dropped, then go FETCH, issuing at target that cycle.
- pcp4 is always the registered pc_addrout+4, 32-bit wrap.

Test Plan:
- Reset, 1-cycle memory returning addr>>2 as data, id_stall=0 → fetches 0x0,0x4,0x8 back-to-back; instrn_valid=1 from cycle 2; pcp4=pc_addrout+4.
- id_stall=1 for 3 cycles with a response arriving → skid captures it; IF/ID unchanged; no imem_req in HOLD; on release, instrn follows in order with no loss or duplication.
- Branch in IF/ID: pcsel=01, branchif=1, pc_brtarg=0x100, memory latency 3 with request pending → next response dropped; next imem_addr=0x100; instrn=0x13, valid=0 until 0x100 data arrives.
- pcsel=01, branchif=0 → no redirect, sequential fetch continues; pcsel=10, jmp_targ=0x203 → fetch at 0x200.
- Redirect and id_stall in the same cycle as imem_rvalid → data dropped, IF/ID flushed, fetch at target next cycle.
- fetch_pc=0xFFFF_FFFC → next fetch 0x0000_0000; rst asserted mid-request → PC returns to RESET_PC and the stale response is ignored.

Source files
------------

// File: rtl/r200_ifetch.sv
// r200_ifetch: instruction-fetch stage of the r200 RV32 pipeline.
// Owns the fetch PC, a single-outstanding-request handshake to instruction
// memory, a one-entry skid buffer for decode back-pressure, and the IF/ID
// pipeline register consumed by decode.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_req/addr     fetch request and word address to instruction memory
//   imem_rvalid/rdata response strobe and instruction word
//   id_stall          decode cannot accept a new instruction this cycle
//   pcsel, branchif   redirect control from decode (01 branch, 10 jump)
//   pc_brtarg         branch target
//   jmp_targ          jump target
//   pc_addrout, pcp4  PC of the IF/ID instruction and PC+4
//   instrn            IF/ID instruction (NOP_INSTR when not valid)
//   instrn_valid      IF/ID holds a live instruction
module r200_ifetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic [1:0]  pcsel,
  input  logic        branchif,
  input  logic [31:0] pc_brtarg,
  input  logic [31:0] jmp_targ,
  output logic [31:0] pc_addrout,
  output logic [31:0] pcp4,
  output logic [31:0] instrn,
  output logic        instrn_valid
);

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  fetch_word_t skid_q, skid_d;
  fetch_word_t ifid_q, ifid_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] pcp4_q;
  logic        req_c;
  logic [31:0] addr_c;
  logic        rsp_c;
  logic        is_branch_c;
  logic        is_jump_c;
  logic        redirect_c;
  logic [31:0] target_c;

  // A response only counts while a request is outstanding; stray strobes are ignored.
  assign rsp_c       = pending_q & imem_rvalid;
  assign is_branch_c = (pcsel == 2'b01) & branchif;
  assign is_jump_c   = (pcsel == 2'b10);
  assign redirect_c  = ifid_valid_q & (is_branch_c | is_jump_c);
  assign target_c    = is_jump_c ? {jmp_targ[31:2], 2'b00} : {pc_brtarg[31:2], 2'b00};

  // Next-state and request logic.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    skid_d       = skid_q;
    ifid_d       = ifid_q;
    ifid_valid_d = ifid_valid_q;
    req_c        = 1'b0;
    addr_c       = fetch_pc_q;

    case (state_q)
      S_FETCH: begin
        if (rsp_c) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          if (id_stall) begin
            // Park the word; no new request until decode drains the skid.
            skid_d  = '{pc: fetch_pc_q, instr: imem_rdata};
            state_d = S_HOLD;
          end else begin
            ifid_d       = '{pc: fetch_pc_q, instr: imem_rdata};
            ifid_valid_d = 1'b1;
            // Back-to-back issue at the following word.
            req_c        = 1'b1;
            addr_c       = fetch_pc_q + PC_STEP;
          end
        end else begin
          req_c = ~pending_q;
          if (!id_stall) begin
            ifid_valid_d = 1'b0;
            ifid_d.instr = NOP_INSTR;
          end
        end
      end
      S_HOLD: begin
        if (!id_stall) begin
          ifid_d       = skid_q;
          ifid_valid_d = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_DISCARD: begin
        // Drop the wrong-path response and issue at the redirect target.
        if (rsp_c) begin
          req_c   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase

    // Redirect overrides everything; the target is issued next cycle.
    if (redirect_c) begin
      ifid_valid_d = 1'b0;
      ifid_d.instr = NOP_INSTR;
      fetch_pc_d   = target_c;
      req_c        = 1'b0;
      state_d      = (pending_q && !imem_rvalid) ? S_DISCARD : S_FETCH;
    end

    if (rst) req_c = 1'b0;
  end

  assign pending_d = req_c | (pending_q & ~imem_rvalid);

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pending_q    <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      skid_q       <= '0;
      ifid_q       <= '{pc: RESET_PC, instr: NOP_INSTR};
      ifid_valid_q <= 1'b0;
      pcp4_q       <= RESET_PC + PC_STEP;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      fetch_pc_q   <= fetch_pc_d;
      skid_q       <= skid_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
      pcp4_q       <= ifid_d.pc + PC_STEP;
    end
  end

  assign imem_req     = req_c;
  assign imem_addr    = addr_c;
  assign pc_addrout   = ifid_q.pc;
  assign pcp4         = pcp4_q;
  assign instrn       = ifid_q.instr;
  assign instrn_valid = ifid_valid_q;

endmodule

// File: tb/tb_r200_ifetch.sv
// Testbench for r200_ifetch: behavioural instruction memory with configurable
// latency, and a scoreboard of expected PCs compared as decode consumes them.
module tb_r200_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic [1:0]  pcsel;
  logic        branchif;
  logic [31:0] pc_brtarg;
  logic [31:0] jmp_targ;
  logic [31:0] pc_addrout;
  logic [31:0] pcp4;
  logic [31:0] instrn;
  logic        instrn_valid;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  bit          mon_en   = 1'b0;
  bit          mem_clr  = 1'b1;
  int          mem_lat  = 1;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr_q;
  logic [31:0] mon_pc;

  r200_ifetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .id_stall     (id_stall),
    .pcsel        (pcsel),
    .branchif     (branchif),
    .pc_brtarg    (pc_brtarg),
    .jmp_targ     (jmp_targ),
    .pc_addrout   (pc_addrout),
    .pcp4         (pcp4),
    .instrn       (instrn),
    .instrn_valid (instrn_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC000_0000 | (a >> 2);
  endfunction

  // Instruction memory: one request at a time, response mem_lat cycles later
  // (mem_lat==0 picks a random latency of 1..4 per request).
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    mem_busy    = 1'b0;
    mem_cnt     = 0;
    mem_addr_q  = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (mem_clr) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr_q);
          mem_busy    = 1'b0;
        end
      end
      #1;
      if (imem_req === 1'b1) begin
        checks++;
        if (mem_busy) begin
          failures++;
          $display("FAIL mem_overlap: got req at %h while busy, expected no request", imem_addr);
        end
        mem_busy   = 1'b1;
        mem_cnt    = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
        mem_addr_q = imem_addr;
        req_log.push_back(imem_addr);
      end
    end
  end

  // Decode-side monitor: every consumed instruction is checked against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && instrn_valid === 1'b1 && id_stall === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_instr: got pc %h, expected none", pc_addrout);
        end else begin
          mon_pc = exp_q.pop_front();
          checks++;
          if (pc_addrout !== mon_pc) begin
            failures++;
            $display("FAIL sb_pc: got %h expected %h", pc_addrout, mon_pc);
          end
          checks++;
          if (instrn !== mem_word(mon_pc)) begin
            failures++;
            $display("FAIL sb_instrn: got %h expected %h", instrn, mem_word(mon_pc));
          end
          checks++;
          if (pcp4 !== mon_pc + 32'd4) begin
            failures++;
            $display("FAIL sb_pcp4: got %h expected %h", pcp4, mon_pc + 32'd4);
          end
        end
      end else if (mon_en && instrn_valid === 1'b0) begin
        checks++;
        if (instrn !== NOP) begin
          failures++;
          $display("FAIL bubble_instrn: got %h expected %h", instrn, NOP);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input bit clr_mem);
    @(negedge clk);
    rst      = 1'b1;
    mon_en   = 1'b0;
    id_stall = 1'b0;
    pcsel    = 2'b00;
    branchif = 1'b0;
    mem_clr  = clr_mem;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    mem_clr = 1'b0;
    req_log.delete();
    exp_q.delete();
    mon_en  = 1'b1;
  endtask

  // Waits (bounded) for the given PC to be live in IF/ID; no checking here.
  task automatic wait_pc(input logic [31:0] pc, output bit found);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (instrn_valid === 1'b1 && pc_addrout === pc) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(output bit drained);
    drained = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (exp_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
      @(negedge clk);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (instrn_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", instrn_valid); end
    checks++; if (instrn !== NOP) begin failures++; $display("FAIL rst_instrn: got %h expected %h", instrn, NOP); end
    checks++; if (pc_addrout !== 32'h0) begin failures++; $display("FAIL rst_pc: got %h expected 0", pc_addrout); end
    checks++; if (pcp4 !== 32'h4) begin failures++; $display("FAIL rst_pcp4: got %h expected 4", pcp4); end
    @(negedge clk);
    rst     = 1'b0;
    mem_clr = 1'b0;
    req_log.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    mon_en = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    @(negedge clk); #1;
    checks++; if (instrn_valid !== 1'b0) begin failures++; $display("FAIL cycle1_valid: got %b expected 0", instrn_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL b2b_req: got req=%b addr=%h expected req=1 addr=4", imem_req, imem_addr); end
    @(negedge clk); #1;
    checks++; if (instrn_valid !== 1'b1 || pc_addrout !== 32'h0) begin failures++; $display("FAIL cycle2_valid: got v=%b pc=%h expected v=1 pc=0", instrn_valid, pc_addrout); end
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL seq_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_stall_skid;
    bit ok;
    mem_lat = 1;
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    wait_pc(32'h4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_wait: got timeout expected pc 4"); end
    id_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL hold_req: got %b expected 0", imem_req); end
      checks++; if (instrn_valid !== 1'b1 || pc_addrout !== 32'h4 || instrn !== mem_word(32'h4)) begin
        failures++; $display("FAIL hold_ifid: got v=%b pc=%h ins=%h expected v=1 pc=4 ins=%h", instrn_valid, pc_addrout, instrn, mem_word(32'h4));
      end
    end
    @(negedge clk);
    id_stall = 1'b0;
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_branch_discard;
    bit ok;
    logic [31:0] got;
    mem_lat = 3;
    do_reset(1'b1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    wait_pc(32'h0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL br_wait: got timeout expected pc 0"); end
    pcsel = 2'b01; branchif = 1'b1; pc_brtarg = 32'h100;
    @(negedge clk);
    pcsel = 2'b00; branchif = 1'b0;
    #1;
    checks++; if (instrn_valid !== 1'b0 || instrn !== NOP) begin failures++; $display("FAIL br_flush: got v=%b ins=%h expected v=0 ins=%h", instrn_valid, instrn, NOP); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL discard_req: got %b expected 0", imem_req); end
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL br_issue: got req=%b addr=%h expected req=1 addr=100", imem_req, imem_addr); end
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL br_drain: got %0d left expected 0", exp_q.size()); end
    got = (req_log.size() > 2) ? req_log[2] : 32'hxxxx_xxxx;
    checks++; if (got !== 32'h100) begin failures++; $display("FAIL br_reqlog: got %h expected 100", got); end
  endtask

  task automatic test_jump_notaken;
    bit ok;
    logic [31:0] got;
    mem_lat = 1;
    do_reset(1'b1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    wait_pc(32'h4, ok);
    checks++; if (!ok) begin failures++; $display("FAIL nt_wait: got timeout expected pc 4"); end
    pcsel = 2'b01; branchif = 1'b0; pc_brtarg = 32'h40;
    @(negedge clk);
    wait_pc(32'h8, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sel11_wait: got timeout expected pc 8"); end
    pcsel = 2'b11; branchif = 1'b1;
    @(negedge clk);
    wait_pc(32'hC, ok);
    checks++; if (!ok) begin failures++; $display("FAIL jmp_wait: got timeout expected pc c"); end
    pcsel = 2'b10; branchif = 1'b0; jmp_targ = 32'h203;
    @(negedge clk);
    pcsel = 2'b00;
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL jmp_drain: got %0d left expected 0", exp_q.size()); end
    got = (req_log.size() > 5) ? req_log[5] : 32'hxxxx_xxxx;
    checks++; if (got !== 32'h200) begin failures++; $display("FAIL jmp_reqlog: got %h expected 200", got); end
  endtask

  task automatic test_redirect_stall_rvalid;
    bit ok;
    logic [31:0] got;
    mem_lat = 1;
    do_reset(1'b1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h300); exp_q.push_back(32'h304);
    wait_pc(32'h8, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rs_wait: got timeout expected pc 8"); end
    pcsel = 2'b10; jmp_targ = 32'h300; id_stall = 1'b1;
    @(negedge clk);
    pcsel = 2'b00; id_stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL rs_issue: got req=%b addr=%h expected req=1 addr=300", imem_req, imem_addr); end
    checks++; if (instrn_valid !== 1'b0 || instrn !== NOP) begin failures++; $display("FAIL rs_flush: got v=%b ins=%h expected v=0 ins=%h", instrn_valid, instrn, NOP); end
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rs_drain: got %0d left expected 0", exp_q.size()); end
    got = (req_log.size() > 4) ? req_log[4] : 32'hxxxx_xxxx;
    checks++; if (got !== 32'h300) begin failures++; $display("FAIL rs_reqlog: got %h expected 300", got); end
  endtask

  task automatic test_pc_wrap;
    bit ok;
    logic [31:0] got;
    mem_lat = 1;
    do_reset(1'b1);
    exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    wait_pc(32'h0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_wait: got timeout expected pc 0"); end
    pcsel = 2'b10; jmp_targ = 32'hFFFF_FFFE;
    @(negedge clk);
    pcsel = 2'b00;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_issue: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req, imem_addr); end
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_drain: got %0d left expected 0", exp_q.size()); end
    got = (req_log.size() > 3) ? req_log[3] : 32'hxxxx_xxxx;
    checks++; if (got !== 32'h0) begin failures++; $display("FAIL wrap_reqlog: got %h expected 0", got); end
  endtask

  task automatic test_reset_midreq;
    bit ok;
    mem_lat = 4;
    do_reset(1'b1);
    exp_q.push_back(32'h0);
    wait_pc(32'h0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mr_wait: got timeout expected pc 0"); end
    // Request for 0x4 is in flight; reset without clearing the memory.
    rst = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mr_req: got %b expected 0", imem_req); end
    checks++; if (instrn_valid !== 1'b0 || pc_addrout !== 32'h0) begin failures++; $display("FAIL mr_state: got v=%b pc=%h expected v=0 pc=0", instrn_valid, pc_addrout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mr_resume: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL mr_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    mem_lat = 0;
    do_reset(1'b1);
    for (int i = 0; i < 30; i++) exp_q.push_back(32'(i * 4));
    for (int c = 0; c < 600 && exp_q.size() > 2; c++) begin
      @(negedge clk);
      id_stall = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    id_stall = 1'b0;
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    rst       = 1'b1;
    id_stall  = 1'b0;
    pcsel     = 2'b00;
    branchif  = 1'b0;
    pc_brtarg = 32'h0;
    jmp_targ  = 32'h0;
    test_reset();
    test_stall_skid();
    test_branch_discard();
    test_jump_notaken();
    test_redirect_stall_rvalid();
    test_pc_wrap();
    test_reset_midreq();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
